// File: rtl/lsu_mem_port.sv
// Memory-access stage load/store unit: drives a req/gnt/rvalid data bus,
// places store lanes, extracts and extends load data, and flags faults.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ma_valid_i,
    input  logic        ma_load_i,
    input  logic        ma_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        access_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [29:0] addr_q;

    logic        live, op_bad, op_mis, accept, timeout_hit;
    logic [31:0] ld_res;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // A flushed instruction raises no exception and issues nothing.
    assign live   = ma_valid_i & ~flush_i & (ma_load_i | ma_store_i);
    assign op_bad = (ma_load_i & ma_store_i)
                  | (ma_load_i & ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)))
                  | (ma_store_i & (funct3_i > 3'b010));
    assign op_mis = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                  | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == (TIMEOUT - 1));
    assign ld_res      = load_extract(funct3_q, off_q, mem_rdata_i);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        stall_o        = 1'b0;
        done_o         = 1'b0;
        misaligned_o   = 1'b0;
        illegal_o      = 1'b0;
        access_fault_o = 1'b0;
        mem_req_o      = 1'b0;
        accept         = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (live && op_bad) begin
                    illegal_o = 1'b1;
                end else if (live && op_mis) begin
                    misaligned_o = 1'b1;
                end else if (live) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                stall_o   = 1'b1;
                if (mem_gnt_i) begin
                    state_d = flush_i ? DRAIN : WAIT;
                    cnt_d   = '0;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                if (mem_rvalid_i) begin
                    stall_o = 1'b0;
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (mem_err_i) begin
                        access_fault_o = 1'b1;
                    end else begin
                        done_o  = 1'b1;
                        rdata_d = we_q ? 32'd0 : ld_res;
                    end
                end else if (timeout_hit) begin
                    stall_o        = 1'b0;
                    access_fault_o = 1'b1;
                    state_d        = IDLE;
                    cnt_d          = '0;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid_i || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata_o     = rdata_d;
    assign mem_we_o    = (state_q == REQ) & we_q;
    assign mem_addr_o  = (state_q == REQ) ? {addr_q, 2'b00} : 32'd0;
    assign mem_be_o    = (state_q == REQ) ? be_q : 4'd0;
    assign mem_wdata_o = (state_q == REQ) ? wdata_q : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are captured once on accept and only exposed while in REQ.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= ma_store_i;
            funct3_q <= funct3_i;
            off_q    <= addr_i[1:0];
            addr_q   <= addr_i[31:2];
            be_q     <= ma_store_i ? store_be(funct3_i, addr_i[1:0]) : 4'b1111;
            wdata_q  <= ma_store_i ? store_data(funct3_i, wdata_i) : 32'd0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port built with a short timeout.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ma_valid_i, ma_load_i, ma_store_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, misaligned_o, illegal_o, access_fault_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ma_valid_i(ma_valid_i), .ma_load_i(ma_load_i), .ma_store_i(ma_store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .misaligned_o(misaligned_o), .illegal_o(illegal_o), .access_fault_o(access_fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        ma_valid_i = 1'b1;
        ma_load_i  = ~st;
        ma_store_i = st;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
    endtask

    task automatic quiet_op();
        ma_valid_i = 1'b0;
        ma_load_i  = 1'b0;
        ma_store_i = 1'b0;
    endtask

    // Zero-wait access: grant on first REQ cycle, response on the next.
    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd);
        present(st, f3, a, wd);
        #1;
        chk({tag, "_acc_stall"}, stall_o, 1);
        chk({tag, "_acc_req"}, mem_req_o, 0);
        tick();
        quiet_op();
        mem_gnt_i = 1'b1;
        #1;
        chk({tag, "_req"}, mem_req_o, 1);
        chk({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
        chk({tag, "_be"}, mem_be_o, exp_be);
        chk({tag, "_we"}, mem_we_o, st);
        if (st) chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
        chk({tag, "_req_stall"}, stall_o, 1);
        tick();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        #1;
        chk({tag, "_wait_req"}, mem_req_o, 0);
        chk({tag, "_done"}, done_o, 1);
        chk({tag, "_rdata"}, rdata_o, exp_rd);
        chk({tag, "_done_stall"}, stall_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk({tag, "_done_drop"}, done_o, 0);
        chk({tag, "_rdata_hold"}, rdata_o, exp_rd);
    endtask

    initial begin
        rst_n = 1'b0;
        quiet_op();
        funct3_i = '0; addr_i = '0; wdata_i = '0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        repeat (3) tick();
        chk("rst_stall", stall_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_be", mem_be_o, 0);
        rst_n = 1'b1;
        tick();

        access("lb",  1'b0, 3'b000, 32'h1003, 0, 32'h80FF1234, 4'hF, 0, 32'hFFFFFF80);
        access("lhu", 1'b0, 3'b101, 32'h2002, 0, 32'hBEEF5555, 4'hF, 0, 32'h0000BEEF);
        access("lh",  1'b0, 3'b001, 32'h2002, 0, 32'hBEEF5555, 4'hF, 0, 32'hFFFFBEEF);

        // Bus error: fault pulse, no done, previous result kept.
        present(1'b0, 3'b010, 32'h50, 0);
        tick();
        quiet_op();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h11111111;
        #1;
        chk("err_fault", access_fault_o, 1);
        chk("err_done", done_o, 0);
        chk("err_rdata", rdata_o, 32'hFFFFBEEF);
        tick();
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        #1;
        chk("err_fault_drop", access_fault_o, 0);

        access("sb", 1'b1, 3'b000, 32'h11, 32'h000000A5, 32'hFFFFFFFF, 4'b0010, 32'hA5A5A5A5, 0);
        access("sh", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'hFFFFFFFF, 4'b1100, 32'h12341234, 0);
        access("sw", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b1111, 32'hDEADBEEF, 0);

        // Misaligned word load and illegal encodings.
        present(1'b0, 3'b010, 32'h1002, 0);
        #1;
        chk("mis_pulse", misaligned_o, 1);
        chk("mis_stall", stall_o, 0);
        chk("mis_req", mem_req_o, 0);
        tick();
        quiet_op();
        #1;
        chk("mis_drop", misaligned_o, 0);
        chk("mis_no_req", mem_req_o, 0);
        present(1'b0, 3'b111, 32'h1000, 0);
        #1;
        chk("ill_ld", illegal_o, 1);
        chk("ill_stall", stall_o, 0);
        present(1'b1, 3'b011, 32'h1000, 0);
        #1;
        chk("ill_st", illegal_o, 1);
        ma_load_i = 1'b1; funct3_i = 3'b010;
        #1;
        chk("ill_both", illegal_o, 1);
        tick();
        quiet_op();
        #1;
        chk("ill_drop", illegal_o, 0);
        chk("ill_no_req", mem_req_o, 0);

        // Grant three cycles late, response two cycles after grant.
        present(1'b1, 3'b010, 32'h40, 32'h01020304);
        #1;
        chk("dly_acc_stall", stall_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            quiet_op();
            mem_gnt_i = (i == 3);
            #1;
            chk("dly_req", mem_req_o, 1);
            chk("dly_addr", mem_addr_o, 32'h40);
            chk("dly_be", mem_be_o, 4'hF);
            chk("dly_stall", stall_o, 1);
        end
        tick();
        mem_gnt_i = 1'b0;
        #1;
        chk("dly_wait_req", mem_req_o, 0);
        chk("dly_wait_stall", stall_o, 1);
        chk("dly_wait_done", done_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("dly_done", done_o, 1);
        chk("dly_done_stall", stall_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        // Timeout of 4 WAIT cycles; late response ignored.
        present(1'b0, 3'b010, 32'h60, 0);
        tick();
        quiet_op();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_early_fault", access_fault_o, 0);
            chk("to_wait_stall", stall_o, 1);
            tick();
        end
        #1;
        chk("to_fault", access_fault_o, 1);
        chk("to_done", done_o, 0);
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("to_late_done", done_o, 0);
        chk("to_late_fault", access_fault_o, 0);
        chk("to_idle_stall", stall_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        access("lbu", 1'b0, 3'b100, 32'h1001, 0, 32'h80FF1234, 4'hF, 0, 32'h00000012);

        // Flush while waiting: response drained silently.
        present(1'b0, 3'b010, 32'h70, 0);
        tick();
        quiet_op();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("fl_wait_done", done_o, 0);
        tick();
        flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        #1;
        chk("fl_drain_done", done_o, 0);
        chk("fl_drain_stall", stall_o, 0);
        chk("fl_drain_fault", access_fault_o, 0);
        chk("fl_drain_rdata", rdata_o, 32'h00000012);
        tick();
        mem_rvalid_i = 1'b0;

        // Flush in REQ without grant returns to IDLE.
        present(1'b0, 3'b010, 32'h74, 0);
        tick();
        quiet_op();
        flush_i = 1'b1;
        #1;
        chk("flr_req", mem_req_o, 1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flr_idle_req", mem_req_o, 0);
        chk("flr_idle_stall", stall_o, 0);

        // Asynchronous reset in REQ.
        present(1'b0, 3'b010, 32'h80, 0);
        tick();
        quiet_op();
        #1;
        chk("rr_req", mem_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", mem_req_o, 0);
        chk("rr_stall", stall_o, 0);
        chk("rr_rdata", rdata_o, 0);
        tick();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        chk("rr_stray_done", done_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        access("lb2", 1'b0, 3'b000, 32'h1001, 0, 32'h80FF1234, 4'hF, 0, 32'h00000012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Data-memory access unit for the Memory Access (MA) stage of the riscv-small pipeline.
- Takes a decoded LOAD_C/STORE_C operation (funct3 per funct3ITypeLOAD_e / funct3SType_e), an effective address and rs2 data.
- Drives a request/grant/response data-memory bus, performing store byte-lane placement and load extraction with sign/zero extension.
- Stalls the pipeline until the memory responds, and reports misalignment, illegal encodings and access faults.

Parameters:
- TIMEOUT, 255: maximum cycles in WAIT for mem_rvalid_i before an access fault is raised. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ma_valid_i  in  1  MA stage holds a valid instruction
- ma_load_i  in  1  operation is LOAD_C
- ma_store_i  in  1  operation is STORE_C
- funct3_i  in  3  load/store funct3
- addr_i  in  32  effective byte address
- wdata_i  in  32  store data (rs2)
- flush_i  in  1  pipeline flush
- stall_o  out  1  hold the pipeline
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load result, valid with done_o
- misaligned_o  out  1  one-cycle misaligned-access pulse
- illegal_o  out  1  one-cycle illegal-encoding pulse
- access_fault_o  out  1  one-cycle bus error or timeout pulse
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_be_o  out  4  byte enables; bit k = byte lane k = bits [8k+7:8k]
- mem_wdata_o  out  32  lane-placed store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid (read data or write acknowledge)
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset: state IDLE; all outputs 0, including rdata_o; timeout counter 0.
- Bus is little-endian: byte lane = addr[1:0].
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE checks, all combinational on the accept cycle:
  - ma_valid_i with both load and store high -> illegal_o pulse.
  - Load funct3 in {011,110,111} or store funct3 > 010 -> illegal_o pulse.
  - Otherwise, halfword with addr[0]=1, or word with addr[1:0]!=0 -> misaligned_o pulse.
  - On any of these pulses: no request, stall_o stays 0.
- IDLE, legal op, flush_i=0:
  - Register we, funct3, addr[1:0], be and wdata.
  - stall_o=1 combinationally in the same cycle; next state REQ.
- REQ:
  - mem_req_o=1, stall_o=1; request fields held stable.
  - mem_gnt_i=1 -> WAIT; mem_req_o drops in the next cycle.
  - flush_i=1 with no grant that cycle -> IDLE, no done_o pulse.
  - Simultaneous grant and flush -> DRAIN.
- WAIT: stall_o=1; counter increments each cycle.
  - mem_rvalid_i=1 -> IDLE, done_o=1 that cycle, stall_o=0 that cycle, counter cleared.
  - mem_err_i=1 with rvalid instead -> access_fault_o pulse, done_o=0.
  - Counter reaches TIMEOUT (nonzero) -> access_fault_o pulse, IDLE; a later rvalid is ignored.
  - flush_i=1 -> DRAIN.
- DRAIN: stall_o=0, no outputs. Wait for mem_rvalid_i (or timeout), discard the response, then IDLE. New ops are not accepted until IDLE.
- Store lane placement:
  - SB: be = 1<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 1111; wdata = wdata_i.
- Loads: be = 1111, mem_we_o=0. Extraction is from mem_rdata_i in the rvalid cycle:
  - LB/LBU: lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: unchanged.
- Stores complete on rvalid with done_o=1 and rdata_o=0.
- rdata_o holds its value until the next done_o.
- mem_rvalid_i in IDLE or REQ is a protocol error and is ignored.
- Reset asserted mid-transaction returns to IDLE immediately and drops mem_req_o; any outstanding response after reset is ignored.

Test Plan:
- LB at 0x1003; gnt same cycle; rvalid next cycle with 0x80FF1234 -> mem_addr_o 0x1000, be 1111; done_o with rdata_o 0xFFFFFF80; stall_o high for exactly 2 cycles.
- LHU at 0x2002 with rdata 0xBEEF5555 -> rdata_o 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- SB at 0x11, wdata 0x000000A5 -> mem_we_o=1, be 0010, mem_wdata_o 0xA5A5A5A5. SH at 0x12, wdata 0x1234 -> be 1100, wdata 0x12341234.
- LW at 0x1002 -> misaligned_o one pulse, mem_req_o never asserts, stall_o 0. Load funct3 111 -> illegal_o pulse.
- Grant delayed 3 cycles, rvalid 2 cycles after grant -> mem_req_o high 4 cycles with stable addr/be; stall_o high 6 cycles; done_o on the rvalid cycle. rvalid with mem_err_i -> access_fault_o, no done_o.
- TIMEOUT=4 with no rvalid -> access_fault_o after 4 WAIT cycles, then IDLE. Flush in WAIT -> DRAIN; a late rvalid produces no done_o. rst_n pulsed low in REQ -> mem_req_o 0 immediately.
